instr_feeder: RTL

- Initiator side of the processor's DIN/Run/Done instruction interface: buffers 9-bit instruction and immediate words in an internal FIFO and issues them to the processor one instruction at a time.
- Replaces the free-running ROM address counter as the DIN source; each instruction is presented with Run, and the block waits for Done before issuing the next.
- Word format: opcode = word[8:6] (000 mv, 001 mvi, 010 add, 011 sub), X = word[5:3], Y = word[2:0].

---
 rtl/instr_feeder.sv | 108 ++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// instr_feeder: FIFO-buffered instruction issuer driving the processor's DIN/Run/Done handshake,
// one instruction at a time, holding back mvi until its immediate is buffered.
module instr_feeder #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          wr_en,
    input  logic [8:0]    wr_data,
    input  logic          enable,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic          full,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          err_ovf,
    output logic          err_timeout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_IMM   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TMO_CNT  = WW'(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   TWO      = (AW+1)'(2);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          ovf_q, ovf_d, tmo_q, tmo_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    head;
    logic          push, pop, is_mvi, can_issue;

    assign head = mem_q[rp_q];

    always_comb begin
        full      = count_q == FULL_CNT;
        push      = wr_en && !full;
        pop       = state_q == S_ISSUE || state_q == S_IMM;
        is_mvi    = head[8:6] == 3'b001;
        can_issue = enable && count_q != '0 && (!is_mvi || count_q >= TWO);
        wp_d      = push ? wp_q + 1'b1 : wp_q;
        rp_d      = pop ? rp_q + 1'b1 : rp_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // A write while full is dropped even if a pop frees a slot this cycle
        ovf_d     = ovf_q | (wr_en & full);
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: if (can_issue) state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = is_mvi ? S_IMM : S_WAIT;
                wcnt_d  = '0;
            end
            S_IMM: begin
                state_d = S_IDLE;
                tmo_d   = tmo_q | ~Done;
            end
            default: begin
                wcnt_d = wcnt_q + 1'b1;
                if (Done) begin
                    state_d = S_IDLE;
                end else if (wcnt_d == TMO_CNT) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wp_q] <= wr_data;
    end

    assign DIN         = pop ? head : '0;
    assign Run         = state_q == S_ISSUE;
    assign busy        = state_q != S_IDLE;
    assign count       = count_q;
    assign err_ovf     = ovf_q;
    assign err_timeout = tmo_q;
endmodule
